// File: rtl/axisr_pkt_meta_split_pkg.sv
// Shared types and widths for axisr_pkt_meta_split.
// The PKT_LEN_CHECK_EN macro only affects the top module's err flag.
package axisr_pkt_meta_split_pkg;

  localparam int PKT_BYTES_BITS = 32;
  localparam int PKT_BEATS_BITS = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BODY = 1'b1
  } hdr_state_e;

  // Upper, fixed-width part of a meta word; tid/tdest sit below it at parameter widths.
  typedef struct packed {
    logic                      err;
    logic [PKT_BEATS_BITS-1:0] beats;
    logic [PKT_BYTES_BITS-1:0] bytes;
  } pkt_meta_t;

  localparam int PKT_META_CNT_BITS = $bits(pkt_meta_t);

endpackage

// File: rtl/axisr_pkt_meta_split_skid_buf.sv
// Two-entry valid/ready register slice: an output register plus one skid slot,
// giving full throughput with a purely registered ready.
module axis_skid_buf
  import axisr_pkt_meta_split_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  logic             outValid_q, outValid_d;
  logic             skidValid_q, skidValid_d;
  logic [WIDTH-1:0] outData_q, outData_d;
  logic [WIDTH-1:0] skidData_q, skidData_d;
  logic             inFire;

  assign in_ready_o = !skidValid_q;
  assign inFire     = in_valid_i && in_ready_o;

  // The output register only changes when empty or draining, so held payload stays stable.
  always_comb begin
    outValid_d  = outValid_q;
    outData_d   = outData_q;
    skidValid_d = skidValid_q;
    skidData_d  = skidData_q;
    if (!outValid_q || out_ready_i) begin
      if (skidValid_q) begin
        outValid_d  = 1'b1;
        outData_d   = skidData_q;
        skidValid_d = 1'b0;
      end else begin
        outValid_d = inFire;
        if (inFire) begin
          outData_d = in_data_i;
        end
      end
    end else if (inFire) begin
      skidValid_d = 1'b1;
      skidData_d  = in_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outValid_q  <= 1'b0;
      outData_q   <= '0;
      skidValid_q <= 1'b0;
      skidData_q  <= '0;
    end else begin
      outValid_q  <= outValid_d;
      outData_q   <= outData_d;
      skidValid_q <= skidValid_d;
      skidData_q  <= skidData_d;
    end
  end

  assign out_valid_o = outValid_q;
  assign out_data_o  = outData_q;

endmodule

// File: rtl/axisr_pkt_meta_split.sv
// Splits a routed packet stream into plain payload plus one meta beat per packet.
// Define PKT_LEN_CHECK_EN to flag packets whose byte count exceeds MAX_PKT_BYTES.
module axisr_pkt_meta_split
  import axisr_pkt_meta_split_pkg::*;
#(
  parameter int DATA_BITS     = 512,
  parameter int ID_BITS       = 6,
  parameter int DEST_BITS     = 14,
  parameter int MAX_PKT_BYTES = 4096,
  parameter int META_BITS     = 512
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [DATA_BITS-1:0]   s_axis_tdata_i,
  input  logic [DATA_BITS/8-1:0] s_axis_tkeep_i,
  input  logic                   s_axis_tlast_i,
  input  logic [ID_BITS-1:0]     s_axis_tid_i,
  input  logic [DEST_BITS-1:0]   s_axis_tdest_i,
  input  logic                   s_axis_tvalid_i,
  output logic                   s_axis_tready_o,
  output logic [DATA_BITS-1:0]   m_axis_tdata_o,
  output logic [DATA_BITS/8-1:0] m_axis_tkeep_o,
  output logic                   m_axis_tlast_o,
  output logic                   m_axis_tvalid_o,
  input  logic                   m_axis_tready_i,
  output logic [META_BITS-1:0]   m_meta_data_o,
  output logic                   m_meta_valid_o,
  input  logic                   m_meta_ready_i
);

  localparam int KEEP_BITS     = DATA_BITS / 8;
  localparam int KEEP_CNT_BITS = $clog2(KEEP_BITS) + 1;
  localparam int PAYLOAD_BITS  = DATA_BITS + KEEP_BITS + 1;
  localparam int SUM_BITS      = PKT_BYTES_BITS + 1;

  hdr_state_e                state_q, state_d;
  logic [ID_BITS-1:0]        tid_q, tid_d;
  logic [DEST_BITS-1:0]      dest_q, dest_d;
  logic [PKT_BYTES_BITS-1:0] bytes_q, bytes_d;
  logic [PKT_BEATS_BITS-1:0] beats_q, beats_d;
  logic                      metaValid_q, metaValid_d;
  logic [META_BITS-1:0]      metaData_q, metaData_d;

  logic                      skidReady, metaFull, lastBlocked, accept, closePkt;
  logic                      firstBeat, pktErr;
  logic [KEEP_CNT_BITS-1:0]  keepCnt;
  logic [SUM_BITS-1:0]       bytesSum;
  logic [PKT_BYTES_BITS-1:0] bytesNext;
  logic [PKT_BEATS_BITS-1:0] beatsNext;
  logic [ID_BITS-1:0]        pktTid;
  logic [DEST_BITS-1:0]      pktDest;
  pkt_meta_t                 metaCnt;
  logic [META_BITS-1:0]      metaWord;
  logic [PAYLOAD_BITS-1:0]   outPayload;

  // A slot that drains this cycle is free, so only a truly held meta stalls a last beat.
  assign metaFull        = metaValid_q && !m_meta_ready_i;
  assign lastBlocked     = metaFull && s_axis_tvalid_i && s_axis_tlast_i;
  assign s_axis_tready_o = skidReady && !lastBlocked && !areset;
  assign accept          = s_axis_tvalid_i && s_axis_tready_o;
  assign closePkt        = accept && s_axis_tlast_i;

  axis_skid_buf #(
    .WIDTH(PAYLOAD_BITS)
  ) dataSkid (
    .clk        (aclk),
    .rst        (areset),
    .in_data_i  ({s_axis_tdata_i, s_axis_tkeep_i, s_axis_tlast_i}),
    .in_valid_i (s_axis_tvalid_i && !lastBlocked && !areset),
    .in_ready_o (skidReady),
    .out_data_o (outPayload),
    .out_valid_o(m_axis_tvalid_o),
    .out_ready_i(m_axis_tready_i)
  );

  assign {m_axis_tdata_o, m_axis_tkeep_o, m_axis_tlast_o} = outPayload;

  always_comb begin
    keepCnt = '0;
    for (int i = 0; i < KEEP_BITS; i++) begin
      keepCnt = keepCnt + KEEP_CNT_BITS'(s_axis_tkeep_i[i]);
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = s_axis_tlast_i ? IDLE : BODY;
    end
  end

  // Running totals including the current beat; on the first beat they restart from it.
  always_comb begin
    firstBeat = (state_q == IDLE);
    pktTid    = firstBeat ? s_axis_tid_i : tid_q;
    pktDest   = firstBeat ? s_axis_tdest_i : dest_q;
    bytesSum  = firstBeat ? SUM_BITS'(keepCnt) : ({1'b0, bytes_q} + SUM_BITS'(keepCnt));
    bytesNext = bytesSum[PKT_BYTES_BITS] ? '1 : bytesSum[PKT_BYTES_BITS-1:0];
    if (firstBeat) begin
      beatsNext = 16'd1;
    end else if (&beats_q) begin
      beatsNext = beats_q;
    end else begin
      beatsNext = beats_q + 16'd1;
    end
  end

`ifdef PKT_LEN_CHECK_EN
  assign pktErr = (bytesNext > PKT_BYTES_BITS'(MAX_PKT_BYTES));
`else
  assign pktErr = 1'b0;
`endif

  always_comb begin
    metaCnt.err   = pktErr;
    metaCnt.beats = beatsNext;
    metaCnt.bytes = bytesNext;
    metaWord = '0;
    metaWord[0 +: ID_BITS] = pktTid;
    metaWord[ID_BITS +: DEST_BITS] = pktDest;
    metaWord[ID_BITS + DEST_BITS +: PKT_META_CNT_BITS] = metaCnt;
  end

  always_comb begin
    tid_d       = tid_q;
    dest_d      = dest_q;
    bytes_d     = bytes_q;
    beats_d     = beats_q;
    metaValid_d = metaValid_q;
    metaData_d  = metaData_q;
    if (accept) begin
      tid_d   = pktTid;
      dest_d  = pktDest;
      bytes_d = bytesNext;
      beats_d = beatsNext;
    end
    if (closePkt) begin
      metaValid_d = 1'b1;
      metaData_d  = metaWord;
    end else if (metaValid_q && m_meta_ready_i) begin
      metaValid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      tid_q       <= '0;
      dest_q      <= '0;
      bytes_q     <= '0;
      beats_q     <= '0;
      metaValid_q <= 1'b0;
      metaData_q  <= '0;
    end else begin
      tid_q       <= tid_d;
      dest_q      <= dest_d;
      bytes_q     <= bytes_d;
      beats_q     <= beats_d;
      metaValid_q <= metaValid_d;
      metaData_q  <= metaData_d;
    end
  end

  assign m_meta_valid_o = metaValid_q;
  assign m_meta_data_o  = metaData_q;

endmodule

// File: tb/tb_axisr_pkt_meta_split.sv
// Scoreboard bench for axisr_pkt_meta_split: a packet table, meta back-pressure,
// random output stalls and a mid-packet reset.
`timescale 1ns/1ps
module tb_axisr_pkt_meta_split;

  localparam int DATA_BITS = 512;
  localparam int KEEP_BITS = 64;
  localparam int ID_BITS   = 6;
  localparam int DEST_BITS = 14;
  localparam int META_BITS = 512;
  localparam int MAX_BYTES = 128;
  localparam logic [63:0] ALL_KEEP = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef PKT_LEN_CHECK_EN
  localparam logic LEN_CHK = 1'b1;
`else
  localparam logic LEN_CHK = 1'b0;
`endif

  logic                 aclk = 1'b0;
  logic                 areset = 1'b1;
  logic [DATA_BITS-1:0] sTdata = '0;
  logic [KEEP_BITS-1:0] sTkeep = '0;
  logic                 sTlast = 1'b0;
  logic [ID_BITS-1:0]   sTid = '0;
  logic [DEST_BITS-1:0] sTdest = '0;
  logic                 sTvalid = 1'b0;
  logic                 sTready;
  logic [DATA_BITS-1:0] mTdata;
  logic [KEEP_BITS-1:0] mTkeep;
  logic                 mTlast;
  logic                 mTvalid;
  logic                 mTready = 1'b1;
  logic [META_BITS-1:0] mMetaData;
  logic                 mMetaValid;
  logic                 mMetaReady = 1'b1;

  typedef struct {
    logic [DATA_BITS-1:0] data;
    logic [KEEP_BITS-1:0] keep;
    logic                 last;
  } beat_t;

  typedef struct {
    int                   nBeats;
    logic [KEEP_BITS-1:0] lastKeep;
    logic [ID_BITS-1:0]   tid;
    logic [DEST_BITS-1:0] dest;
    logic [31:0]          expBytes;
    logic [15:0]          expBeats;
    logic                 expErr;
  } vec_t;

  beat_t                dataQ[$];
  logic [META_BITS-1:0] metaQ[$];
  int                   checks = 0;
  int                   errors = 0;
  bit                   randReady = 1'b0;

  axisr_pkt_meta_split #(
    .DATA_BITS    (DATA_BITS),
    .ID_BITS      (ID_BITS),
    .DEST_BITS    (DEST_BITS),
    .MAX_PKT_BYTES(MAX_BYTES),
    .META_BITS    (META_BITS)
  ) dut (
    .aclk           (aclk),
    .areset         (areset),
    .s_axis_tdata_i (sTdata),
    .s_axis_tkeep_i (sTkeep),
    .s_axis_tlast_i (sTlast),
    .s_axis_tid_i   (sTid),
    .s_axis_tdest_i (sTdest),
    .s_axis_tvalid_i(sTvalid),
    .s_axis_tready_o(sTready),
    .m_axis_tdata_o (mTdata),
    .m_axis_tkeep_o (mTkeep),
    .m_axis_tlast_o (mTlast),
    .m_axis_tvalid_o(mTvalid),
    .m_axis_tready_i(mTready),
    .m_meta_data_o  (mMetaData),
    .m_meta_valid_o (mMetaValid),
    .m_meta_ready_i (mMetaReady)
  );

  // 100 MHz clock
  initial forever #5 aclk = ~aclk;

  // Payload back-pressure, changed just after each rising edge
  always @(posedge aclk) begin
    #1;
    mTready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic checkOutput(input string name, input logic [639:0] got, input logic [639:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [META_BITS-1:0] packMeta(input logic [5:0] tid, input logic [13:0] dest,
                                                   input logic [31:0] bytes, input logic [15:0] beats,
                                                   input logic err);
    logic [META_BITS-1:0] w;
    w = '0;
    w[5:0]   = tid;
    w[19:6]  = dest;
    w[51:20] = bytes;
    w[67:52] = beats;
    w[68]    = err;
    return w;
  endfunction

  function automatic logic [DATA_BITS-1:0] randData();
    logic [DATA_BITS-1:0] d;
    for (int i = 0; i < DATA_BITS / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Payload scoreboard plus hold-stability while stalled
  logic                   dStall = 1'b0;
  logic [DATA_BITS+KEEP_BITS:0] dPrev = '0;
  always @(negedge aclk) begin
    beat_t b;
    if (areset) begin
      dStall = 1'b0;
    end else begin
      if (dStall && mTvalid) checkOutput("holdPayload", {mTdata, mTkeep, mTlast}, dPrev);
      if (mTvalid && mTready) begin
        if (dataQ.size() == 0) begin
          checkOutput("payloadUnexpected", dataQ.size() + 1, 0);
        end else begin
          b = dataQ.pop_front();
          checkOutput("payload", {mTdata, mTkeep, mTlast}, {b.data, b.keep, b.last});
        end
      end
      dStall = mTvalid && !mTready;
      dPrev  = {mTdata, mTkeep, mTlast};
    end
  end

  // Meta scoreboard plus hold-stability while stalled
  logic                 mStall = 1'b0;
  logic [META_BITS-1:0] mPrev = '0;
  always @(negedge aclk) begin
    logic [META_BITS-1:0] e;
    if (areset) begin
      mStall = 1'b0;
    end else begin
      if (mStall && mMetaValid) checkOutput("holdMeta", mMetaData, mPrev);
      if (mMetaValid && mMetaReady) begin
        if (metaQ.size() == 0) begin
          checkOutput("metaUnexpected", metaQ.size() + 1, 0);
        end else begin
          e = metaQ.pop_front();
          checkOutput("meta", mMetaData, e);
        end
      end
      mStall = mMetaValid && !mMetaReady;
      mPrev  = mMetaData;
    end
  end

  // Drive one beat from just after a rising edge until it is accepted
  task automatic applyStimulus(input logic [DATA_BITS-1:0] d, input logic [KEEP_BITS-1:0] k,
                               input logic l, input logic [ID_BITS-1:0] tid,
                               input logic [DEST_BITS-1:0] dest, input logic [META_BITS-1:0] expMeta,
                               output int waited);
    logic got;
    beat_t b;
    sTdata = d; sTkeep = k; sTlast = l; sTid = tid; sTdest = dest; sTvalid = 1'b1;
    got = 1'b0;
    waited = 0;
    while (!got && waited < 2000) begin
      @(negedge aclk);
      if (sTready) begin
        got = 1'b1;
        b.data = d; b.keep = k; b.last = l;
        dataQ.push_back(b);
        if (l) metaQ.push_back(expMeta);
      end else begin
        waited++;
      end
      @(posedge aclk); #1;
    end
    sTvalid = 1'b0;
    if (!got) checkOutput("acceptTimeout", got, 1);
  endtask

  task automatic sendPacket(input int n, input logic [KEEP_BITS-1:0] lastKeep,
                            input logic [ID_BITS-1:0] tid, input logic [DEST_BITS-1:0] dest,
                            input logic [META_BITS-1:0] expMeta);
    int w;
    for (int i = 0; i < n; i++) begin
      applyStimulus(randData(), (i == n - 1) ? lastKeep : ALL_KEEP, i == n - 1,
                    tid + ID_BITS'(i), dest ^ DEST_BITS'(i), expMeta, w);
    end
  endtask

  task automatic waitDrain(input string name);
    int c = 0;
    while ((dataQ.size() != 0 || metaQ.size() != 0) && c < 2000) begin
      @(posedge aclk);
      c++;
    end
    #1;
    checkOutput(name, dataQ.size() + metaQ.size(), 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=running exp=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[7];
    int   w;
    vecs[0] = '{1, ALL_KEEP,                6'd3,  14'h15,   32'd64,  16'd1, 1'b0};
    vecs[1] = '{4, 64'h0000_0000_0000_000F, 6'd5,  14'h2A,   32'd196, 16'd4, LEN_CHK};
    vecs[2] = '{3, ALL_KEEP,                6'd1,  14'h3FFF, 32'd192, 16'd3, LEN_CHK};
    vecs[3] = '{2, ALL_KEEP,                6'h2A, 14'h0,    32'd128, 16'd2, 1'b0};
    vecs[4] = '{3, 64'h0000_0000_0000_0001, 6'd7,  14'h100,  32'd129, 16'd3, LEN_CHK};
    vecs[5] = '{1, 64'h0000_0000_0000_0001, 6'h3F, 14'h1,    32'd1,   16'd1, 1'b0};
    vecs[6] = '{2, 64'h0000_0000_FF00_FF00, 6'd9,  14'h77,   32'd80,  16'd2, 1'b0};

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    checkOutput("rstTready", sTready, 0);
    checkOutput("rstTvalid", mTvalid, 0);
    checkOutput("rstMetaValid", mMetaValid, 0);
    checkOutput("rstPayload", {mTdata, mTkeep, mTlast}, 0);
    checkOutput("rstMetaData", mMetaData, 0);
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    checkOutput("readyAfterReset", sTready, 1);
    @(posedge aclk); #1;

    $display("[TB] packet table");
    for (int v = 0; v < 7; v++) begin
      sendPacket(vecs[v].nBeats, vecs[v].lastKeep, vecs[v].tid, vecs[v].dest,
                 packMeta(vecs[v].tid, vecs[v].dest, vecs[v].expBytes, vecs[v].expBeats, vecs[v].expErr));
    end
    waitDrain("drainTable");

    $display("[TB] meta back-pressure");
    mMetaReady = 1'b0;
    sendPacket(1, ALL_KEEP, 6'd7, 14'h10, packMeta(6'd7, 14'h10, 32'd64, 16'd1, 1'b0));
    sTdata = randData(); sTkeep = ALL_KEEP; sTlast = 1'b1; sTid = 6'd9; sTdest = 14'h11; sTvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      checkOutput("lastStalled", sTready, 0);
      @(posedge aclk); #1;
    end
    mMetaReady = 1'b1;
    applyStimulus(sTdata, ALL_KEEP, 1'b1, 6'd9, 14'h11, packMeta(6'd9, 14'h11, 32'd64, 16'd1, 1'b0), w);
    checkOutput("freeReloadWait", w, 0);
    waitDrain("drainStall");

    $display("[TB] random payload back-pressure");
    randReady = 1'b1;
    for (int p = 0; p < 100; p++) begin
      int n, k;
      logic [KEEP_BITS-1:0] lk;
      logic [31:0] by;
      logic [ID_BITS-1:0] t;
      logic [DEST_BITS-1:0] d;
      n  = $urandom_range(1, 4);
      k  = $urandom_range(1, 64);
      lk = (k == 64) ? ALL_KEEP : ((64'd1 << k) - 64'd1);
      by = 32'((n - 1) * 64 + k);
      t  = ID_BITS'($urandom);
      d  = DEST_BITS'($urandom);
      sendPacket(n, lk, t, d, packMeta(t, d, by, 16'(n), LEN_CHK && (by > 32'd128)));
    end
    waitDrain("drainRandom");
    randReady = 1'b0;
    @(posedge aclk); #1;

    $display("[TB] reset mid-packet");
    applyStimulus(randData(), ALL_KEEP, 1'b0, 6'd2, 14'h5, '0, w);
    applyStimulus(randData(), ALL_KEEP, 1'b0, 6'd2, 14'h5, '0, w);
    areset = 1'b1;
    dataQ.delete();
    @(negedge aclk);
    checkOutput("midRstTvalid", mTvalid, 0);
    checkOutput("midRstPayload", {mTdata, mTkeep, mTlast}, 0);
    checkOutput("midRstMetaValid", mMetaValid, 0);
    checkOutput("midRstTready", sTready, 0);
    @(posedge aclk); #1;
    areset = 1'b0;
    sendPacket(3, ALL_KEEP, 6'd4, 14'h22, packMeta(6'd4, 14'h22, 32'd192, 16'd3, LEN_CHK));
    waitDrain("drainAfterReset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axisr_pkt_meta_split.md
# axisr_pkt_meta_split

Per-packet splitter between the routed user stream and the host/network data path. It consumes an AXI4SR packet stream and forwards the payload unchanged as a plain AXI4S stream. For each packet it emits one LMetaIntf beat carrying tid, tdest, byte count, beat count and an error flag. The block sits directly downstream of any AXI4SR producer and feeds AXI4S consumers plus a metadata queue.

## Interface
- DATA_BITS, AXI_DATA_BITS: stream data width in bits; DATA_BITS/8 keep bits.
- ID_BITS, PID_BITS: tid width.
- DEST_BITS, 14: tdest width.
- MAX_PKT_BYTES, 4096: oversize threshold, used only with PKT_LEN_CHECK_EN.
- META_BITS, AXI_DATA_BITS: LMetaIntf data width; must be ≥ ID_BITS+DEST_BITS+49.

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous, active-high reset.
- s_axis  AXI4SR.s  DATA_BITS/ID_BITS/DEST_BITS  routed input stream.
- m_axis  AXI4S.m  DATA_BITS  payload output stream.
- m_meta  LMetaIntf.m  META_BITS  one beat per packet.

## Operation
- Data path: a 2-entry skid buffer. tdata, tkeep and tlast pass unmodified. tid and tdest are dropped from the data stream.
- Header FSM states:
  - IDLE: next accepted beat is a packet start. On that beat, capture tid/tdest and go to BODY. If the same beat has tlast, close the packet and stay in IDLE.
  - BODY: accumulate counts. The beat with tlast closes the packet and returns to IDLE.
  - tid/tdest on non-first beats are ignored.
- bytes: 32-bit accumulator of popcount(tkeep) per accepted beat.
  - Popcount width is $clog2(DATA_BITS/8)+1, zero-extended before adding.
  - Saturates at 2^32-1.
- beats: 16-bit counter, saturates at 0xFFFF.
- Meta packing, LSB first: tid[ID_BITS], tdest[DEST_BITS], bytes[32], beats[16], err[1]. Upper bits are 0.
- Meta output is a 1-entry register. It loads on packet close and clears on m_meta.valid && m_meta.ready.
- Accept rule: s_axis.tready = skid_not_full && !(meta_full && s_axis.tvalid && s_axis.tlast).
  - This may depend on tvalid/tlast. A last beat stalls until the meta slot is free.
  - A meta slot that frees and reloads in the same cycle counts as free.

## Timing
- Reset values:
  - m_axis.tvalid=0, m_meta.valid=0; tdata/tkeep/tlast/data=0.
  - s_axis.tready=0 while areset is asserted, and 1 the first cycle after release.
  - FSM=IDLE, counters=0.
- Data latency: 1 cycle from acceptance to m_axis.tvalid. Full throughput: 1 beat/cycle with m_axis.tready high.
- Meta latency: m_meta.valid rises the cycle after the tlast beat is accepted.
  - Meta may precede the corresponding m_axis tlast beat; no ordering between the two outputs is guaranteed.
- Back-to-back single-beat packets sustain 1 packet/cycle only if m_meta.ready is held high.
- Held outputs (m_axis payload, m_meta.data) stay stable while valid && !ready.
- Reset mid-packet: the partial packet is discarded, buffered beats are lost, and no meta is emitted.

## Configuration
- PKT_LEN_CHECK_EN defined:
  - err=1 when the final bytes > MAX_PKT_BYTES.
  - Data is still forwarded in full.
- PKT_LEN_CHECK_EN undefined: err is tied to 0 and no comparator is built.

## Structure
- lynxTypes gains:
  - the pkt_meta_t packed struct (fields as packed above);
  - PKT_BYTES_BITS=32 and PKT_BEATS_BITS=16;
  - the FSM state enum.
- Sub-module axis_skid_buf: a 2-entry valid/ready register slice parameterised on payload width. It is reused for the data path.
- Everything else (FSM, counters, meta register) lives in the top module.

## Test plan
- Single beat: tkeep=all-ones, tid=3, tdest=0x15, tlast=1 → m_meta beats=1, bytes=DATA_BITS/8, tid=3, tdest=0x15, err=0; payload identical.
- 4-beat packet, last tkeep=0x000F (DATA_BITS=512), tid changes on beats 2–4 → bytes=196, beats=4, tid from beat 1.
- m_meta.ready=0 with two packets sent → second tlast beat stalled (tready=0) until the first meta is taken; no meta lost or duplicated.
- Random m_axis.ready 50% over 100 packets → output stream bit-exact to input; held payload stable while stalled.
- areset pulse after 2 beats of a 5-beat packet → outputs 0; next packet's meta counts only its own beats.
- With PKT_LEN_CHECK_EN and MAX_PKT_BYTES=128, 3 full 64-B beats → bytes=192, err=1; without the macro, err=0.
